// File: rtl/aec_pkg.sv
// Shared definitions for the AEC expression link: character codes, the
// legal-character check and the transmitter state encoding.
package aec_pkg;

    localparam logic [7:0] ASC_0   = 8'h30;
    localparam logic [7:0] ASC_9   = 8'h39;
    localparam logic [7:0] ASC_A   = 8'h61;
    localparam logic [7:0] ASC_F   = 8'h66;
    localparam logic [7:0] ASC_ADD = 8'h2B;
    localparam logic [7:0] ASC_SUB = 8'h2D;
    localparam logic [7:0] ASC_MUL = 8'h2A;
    localparam logic [7:0] ASC_LP  = 8'h28;
    localparam logic [7:0] ASC_RP  = 8'h29;
    localparam logic [7:0] ASC_EQ  = 8'h3D;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        SEND,
        WAIT_RES,
        DONE
    } aec_state_e;

    function automatic logic is_legal_char(input logic [7:0] c);
        return ((c >= ASC_0) && (c <= ASC_9)) ||
               ((c >= ASC_A) && (c <= ASC_F)) ||
               (c inside {ASC_ADD, ASC_SUB, ASC_MUL, ASC_LP, ASC_RP, ASC_EQ});
    endfunction

endpackage

// File: rtl/aec_char_buf.sv
// Append-only character store with an indexed read port; exposes the fill
// level, a full flag and the most recently appended entry.
module aec_char_buf #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          clr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_idx,
    output logic [7:0]    rd_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic [7:0]    last
);

    logic [7:0] mem [DEPTH];

    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + CW'(1);
        end
    end

    // NOTE: the storage array has no reset; only count decides which entries
    // are meaningful, so old contents survive reset by design.
    always_ff @(posedge clk) begin
        if (rst && push && !clr && !full) begin
            mem[count[AW-1:0]] <= wr_data;
        end
    end

    assign full    = (count == CW'(DEPTH));
    assign rd_data = mem[rd_idx];
    assign last    = mem[AW'(count - CW'(1))];

endmodule

// File: rtl/aec_expr_tx.sv
// Upstream end of the AEC link: buffers a host-loaded expression, replays it
// to the evaluator on start, then waits (bounded) for the evaluator's result.
module aec_expr_tx
    import aec_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 255,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          clr,
    input  logic          start,
    input  logic          valid,
    input  logic [6:0]    result,
    output logic          ready,
    output logic [7:0]    ascii_out,
    output logic          busy,
    output logic          done,
    output logic [6:0]    res_out,
    output logic          timeout,
    output logic          err,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    aec_state_e    state, state_d;
    logic [AW-1:0] ptr, ptr_d, rd_idx;
    logic [TW-1:0] timer, timer_d;
    logic [7:0]    rd_data, last, ascii_d;
    logic [6:0]    res_d;
    logic          ready_d, busy_d, done_d, err_d, timeout_d;
    logic          is_idle, full, wr_ok, wr_rej, start_ok, start_rej;

    assign is_idle   = (state == IDLE);
    assign wr_ok     = is_idle && wr_en && !clr && is_legal_char(wr_data) && !full;
    assign wr_rej    = wr_en && !(is_idle && clr) && !wr_ok;
    assign start_ok  = is_idle && start && (count != '0) && (last == ASC_EQ);
    assign start_rej = is_idle && start && !start_ok;
    // SEND reads one entry ahead so the next character is ready at the edge.
    assign rd_idx    = (state == SEND) ? ptr + AW'(1) : '0;

    aec_char_buf #(.DEPTH(DEPTH)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .push    (wr_ok),
        .clr     (is_idle && clr),
        .wr_data (wr_data),
        .rd_idx  (rd_idx),
        .rd_data (rd_data),
        .count   (count),
        .full    (full),
        .last    (last)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state;
        ptr_d     = ptr;
        timer_d   = timer;
        ascii_d   = '0;
        ready_d   = 1'b0;
        res_d     = res_out;
        timeout_d = timeout;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_d   = PREP;
                    ready_d   = 1'b1;
                    ascii_d   = rd_data;
                    timeout_d = 1'b0;
                    ptr_d     = '0;
                end
            end
            PREP: begin
                state_d = SEND;
                ascii_d = rd_data;
                ptr_d   = '0;
            end
            SEND: begin
                // The character on the bus now is entry[ptr]; stop after the first '='.
                if ((ascii_out == ASC_EQ) || (CW'(ptr) == count - CW'(1))) begin
                    state_d = WAIT_RES;
                    timer_d = '0;
                end else begin
                    ascii_d = rd_data;
                    ptr_d   = ptr + AW'(1);
                end
            end
            WAIT_RES: begin
                if (valid) begin
                    res_d   = result;
                    state_d = DONE;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    res_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    timer_d = timer + TW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        // A write dropped in the final waiting cycle keeps err off the done cycle.
        err_d  = (wr_rej || start_rej) && (state_d != DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= '0;
            timer     <= '0;
            ready     <= 1'b0;
            ascii_out <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            res_out   <= '0;
            timeout   <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            timer     <= timer_d;
            ready     <= ready_d;
            ascii_out <= ascii_d;
            busy      <= busy_d;
            done      <= done_d;
            res_out   <= res_d;
            timeout   <= timeout_d;
            err       <= err_d;
        end
    end

endmodule
